alu_shift_sequencer: RTL and testbench

//  Multi-bit shift/rotate sequencer wrapped around the single-bit combinational alu.
//  - Accepts one shift/rotate request (operand, op, count) at a time.
//  - Drives alu_op/alu_a for one iteration per clock and feeds alu_r back into its accumulator.
//  - Returns the final value and the carry-out (last bit shifted out).
//  - Sits between the execution-unit microcode and the alu.

---
 rtl/alu_shift_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_shift_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// Multi-bit shift/rotate sequencer: iterates the single-bit combinational alu once per clock,
// feeding alu_r back into an accumulator until the masked count is exhausted.
module alu_shift_sequencer #(
    parameter int unsigned COUNT_BITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [15:0] operand,
    input  logic [7:0]  count,
    input  logic        cf_in,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cf_out,
    output logic        err,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_r
);

    localparam logic [3:0] OpShl = 4'd2;
    localparam logic [3:0] OpShr = 4'd3;
    localparam logic [3:0] OpRol = 4'd4;
    localparam logic [3:0] OpRor = 4'd5;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t                state_q, state_d;
    logic [15:0]           acc_q, acc_d;
    logic [3:0]            op_q, op_d;
    logic [COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [15:0]           result_q, result_d;
    logic                  cf_q, cf_d;
    logic                  err_q, err_d;

    logic [COUNT_BITS-1:0] count_masked;
    logic                  op_valid;
    logic                  shifts_left;

    assign count_masked = count[COUNT_BITS-1:0];
    assign op_valid     = (op == OpShl) || (op == OpShr) || (op == OpRol) || (op == OpRor);
    // Left-moving ops lose the MSB; right-moving ops lose the LSB.
    assign shifts_left  = (op_q == OpShl) || (op_q == OpRol);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cf_d     = cf_q;
        err_d    = err_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    acc_d = operand;
                    op_d  = op;
                    cnt_d = count_masked;
                    if (!op_valid) begin
                        state_d  = StDone;
                        result_d = operand;
                        cf_d     = cf_in;
                        err_d    = 1'b1;
                    end else if (count_masked == '0) begin
                        state_d  = StDone;
                        result_d = operand;
                        cf_d     = cf_in;
                        err_d    = 1'b0;
                    end else begin
                        state_d = StRun;
                        err_d   = 1'b0;
                    end
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                acc_d = alu_r;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == COUNT_BITS'(1)) begin
                    result_d = alu_r;
                    cf_d     = shifts_left ? acc_q[15] : acc_q[0];
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cf_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cf_q     <= cf_d;
            err_q    <= err_d;
        end
    end

    assign ready  = (state_q != StRun);
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign cf_out = cf_q;
    assign err    = err_q;
    assign alu_op = (state_q == StRun) ? op_q : 4'd0;
    assign alu_a  = acc_q;
    assign alu_b  = 16'h0000;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a behavioural single-bit alu in the loop.
module tb_alu_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [15:0] operand;
    logic [7:0]  count;
    logic        cf_in;
    logic        ready, busy, done, cf_out, err;
    logic [15:0] result, alu_a, alu_b, alu_r;
    logic [3:0]  alu_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_shift_sequencer #(.COUNT_BITS(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .operand (operand),
        .count   (count),
        .cf_in   (cf_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cf_out  (cf_out),
        .err     (err),
        .alu_op  (alu_op),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_r   (alu_r)
    );

    // Single-bit alu: logical shifts fill with zero, rotates wrap.
    always_comb begin
        case (alu_op)
            4'd2:    alu_r = {alu_a[14:0], 1'b0};
            4'd3:    alu_r = {1'b0, alu_a[15:1]};
            4'd4:    alu_r = {alu_a[14:0], alu_a[15]};
            4'd5:    alu_r = {alu_a[0], alu_a[15:1]};
            default: alu_r = alu_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start for one cycle, then counts negedges until done (bounded).
    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [7:0] c,
                         input logic cf, output int lat);
        op      = o;
        operand = a;
        count   = c;
        cf_in   = cf;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        operand = 16'hFFFF;
        op      = 4'd0;
        count   = 8'd0;
        lat     = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [15:0] a,
                       input logic [7:0] c, input logic cf, input int exp_lat,
                       input logic [15:0] exp_res, input logic exp_cf, input logic exp_err);
        int lat;
        issue(o, a, c, cf, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " cf_out"}, 32'(cf_out), 32'(exp_cf));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " ready"}, 32'(ready), 32'd1);
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int saw_done;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 4'd0;
        operand = 16'h0;
        count   = 8'd0;
        cf_in   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst ready", 32'(ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst alu_op", 32'(alu_op), 32'd0);
        check("rst alu_b", 32'(alu_b), 32'd0);

        run("shl4",    4'd2, 16'h0001, 8'd4,    1'b0, 5,  16'h0010, 1'b0, 1'b0);
        run("ror1",    4'd5, 16'h0001, 8'd1,    1'b0, 2,  16'h8000, 1'b1, 1'b0);
        run("shr_msk", 4'd3, 16'h8001, 8'h21,   1'b0, 2,  16'h4000, 1'b1, 1'b0);
        run("shl0",    4'd2, 16'h1234, 8'd0,    1'b1, 1,  16'h1234, 1'b1, 1'b0);
        run("shl_cf",  4'd2, 16'h8000, 8'd1,    1'b0, 2,  16'h0000, 1'b1, 1'b0);
        run("ror31",   4'd5, 16'h0001, 8'd31,   1'b1, 32, 16'h0002, 1'b0, 1'b0);

        // Invalid op: immediate done with err, no RUN cycle ever drives the alu.
        op = 4'd0; operand = 16'hBEEF; count = 8'd3; cf_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("add done", 32'(done), 32'd1);
        check("add err", 32'(err), 32'd1);
        check("add result", 32'(result), 32'hBEEF);
        check("add alu_op", 32'(alu_op), 32'd0);
        check("add busy", 32'(busy), 32'd0);
        @(negedge clk);

        // ROL x16 with a stray start during RUN, then a back-to-back request in the done cycle.
        op = 4'd4; operand = 16'hA5A5; count = 8'd16; cf_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        check("rol busy", 32'(busy), 32'd1);
        check("rol alu_op", 32'(alu_op), 32'd4);
        while (!done && lat < 40) begin
            if (lat == 3) begin
                op = 4'd2; operand = 16'h0F0F; count = 8'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check("rol16 latency", 32'(lat), 32'd17);
        check("rol16 result", 32'(result), 32'hA5A5);
        check("rol16 cf_out", 32'(cf_out), 32'd1);
        check("rol16 err", 32'(err), 32'd0);
        check("b2b ready", 32'(ready), 32'd1);
        issue(4'd3, 16'h0003, 8'd2, 1'b0, lat);
        check("b2b latency", 32'(lat), 32'd3);
        check("b2b result", 32'(result), 32'h0000);
        check("b2b cf_out", 32'(cf_out), 32'd1);
        @(negedge clk);

        // Reset mid-RUN: abort to IDLE with reset values and no done pulse.
        op = 4'd4; operand = 16'hA5A5; count = 8'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-rst busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort ready", 32'(ready), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort cf_out", 32'(cf_out), 32'd0);
        check("abort err", 32'(err), 32'd0);
        check("abort alu_op", 32'(alu_op), 32'd0);
        check("abort alu_a", 32'(alu_a), 32'd0);
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) saw_done = 1;
            @(negedge clk);
        end
        check("abort no done", 32'(saw_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
